// File: rtl/systolic_tile_sched_pkg.sv
// Shared types and constants for the systolic tile scheduler.
package systolic_tile_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN,
      DONE
   } sched_state_t;

   typedef logic [2:0] full_type_t;

   localparam int SCHED_KMAX = 256;

   // Number of cycles the array needs to flush after the last operand enters
   function automatic int DRAIN_LAT(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/systolic_tile_sched_if.sv
// Tile command channel between the command queue and the scheduler.
interface systolic_tile_sched_if
   import systolic_tile_sched_pkg::*;
#(
   parameter int KW = 9
) ();

   logic            cmd_valid;
   logic            cmd_ready;
   logic [KW-1:0]   cmd_k_len;
   logic            cmd_load_c;
   full_type_t      cmd_type;

   modport master (
      output cmd_valid,
      output cmd_k_len,
      output cmd_load_c,
      output cmd_type,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_k_len,
      input  cmd_load_c,
      input  cmd_type,
      output cmd_ready
   );

endinterface

// File: rtl/systolic_tile_sched_wavefront_gen.sv
// Per-lane skewed enable window: lane i is active while i <= t < i+K.
module systolic_tile_sched_wavefront_gen #(
   parameter int N  = 8,
   parameter int TW = 9,
   parameter int KW = 9
) (
   input  logic [TW-1:0] t,
   input  logic [KW-1:0] k,
   output logic [N-1:0]  win
);

   // One extra bit so lane index plus K never wraps
   localparam int CW = TW + 1;

   logic [CW-1:0] t_ext;
   logic [CW-1:0] k_ext;

   assign t_ext = {1'b0, t};
   assign k_ext = CW'(k);

   // Window compare for every lane
   always_comb begin
      win = '0;
      for (int i = 0; i < N; i++) begin
         win[i] = (t_ext >= CW'(i)) && (t_ext < (CW'(i) + k_ext));
      end
   end

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile sequencer: accepts one matmul tile command, drives the skewed edge
// enables of the PE array, waits out the fill/drain latency, pulses done.
module systolic_tile_sched
   import systolic_tile_sched_pkg::*;
#(
   parameter int N    = 8,
   parameter int KMAX = SCHED_KMAX,
   parameter int KW   = $clog2(KMAX + 1),
   parameter int TW   = $clog2(KMAX + 3 * N)
) (
   input  logic                 clk,
   input  logic                 rst,
   systolic_tile_sched_if.slave cmd,
   input  logic                 abort,
   output logic [N-1:0]         en_left,
   output logic [N-1:0]         en_up,
   output logic [N-1:0]         cin_left,
   output logic                 cm_left,
   output logic [TW-1:0]        feed_t,
   output full_type_t           type_out,
   output logic                 busy,
   output logic                 done
);

   localparam int            CW     = TW + 1;
   localparam logic [TW-1:0] D_LAST = TW'(DRAIN_LAT(N) - 1);

   sched_state_t  state;
   sched_state_t  state_nxt;
   logic [TW-1:0] t_q;
   logic [TW-1:0] t_nxt;
   logic [TW-1:0] d_q;
   logic [TW-1:0] d_nxt;
   logic [KW-1:0] k_q;
   logic [KW-1:0] k_nxt;
   logic [KW-1:0] k_clamped;
   logic          load_c_q;
   logic          load_c_nxt;
   logic          ready_q;
   logic          accept;
   logic [CW-1:0] stream_end;
   logic [N-1:0]  row_win;
   logic [N-1:0]  col_win;
   logic [N-1:0]  cin_nxt;

   assign cmd.cmd_ready = ready_q;
   assign accept        = (state == IDLE) && cmd.cmd_valid && ready_q;
   assign k_clamped     = (cmd.cmd_k_len > KW'(KMAX)) ? KW'(KMAX) : cmd.cmd_k_len;
   // Last STREAM index is K+N-2; modular add keeps N=1 correct as well
   assign stream_end    = CW'(k_q) + CW'(N - 2);

   // Next-state and counter logic; outputs are then registered from these
   // next values so every output lines up with the state it belongs to
   always_comb begin
      state_nxt  = state;
      t_nxt      = t_q;
      d_nxt      = d_q;
      k_nxt      = k_q;
      load_c_nxt = load_c_q;
      case (state)
         IDLE: begin
            if (accept) begin
               k_nxt      = k_clamped;
               load_c_nxt = cmd.cmd_load_c;
               t_nxt      = '0;
               d_nxt      = '0;
               state_nxt  = (k_clamped == '0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (CW'(t_q) == stream_end) begin
               state_nxt = DRAIN;
               d_nxt     = '0;
            end else begin
               t_nxt = t_q + TW'(1);
            end
         end
         DRAIN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (d_q == D_LAST) begin
               state_nxt = DONE;
            end else begin
               d_nxt = d_q + TW'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   systolic_tile_sched_wavefront_gen #(
      .N  (N),
      .TW (TW),
      .KW (KW)
   ) u_row_wave (
      .t   (t_nxt),
      .k   (k_nxt),
      .win (row_win)
   );

   systolic_tile_sched_wavefront_gen #(
      .N  (N),
      .TW (TW),
      .KW (KW)
   ) u_col_wave (
      .t   (t_nxt),
      .k   (k_nxt),
      .win (col_win)
   );

   // Accumulator-load strobe: one pulse per row, on that row's first enable
   always_comb begin
      cin_nxt = '0;
      for (int i = 0; i < N; i++) begin
         cin_nxt[i] = (state_nxt == STREAM) && load_c_nxt && (t_nxt == TW'(i));
      end
   end

   // State and tile-parameter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         t_q      <= '0;
         d_q      <= '0;
         k_q      <= '0;
         load_c_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         t_q      <= t_nxt;
         d_q      <= d_nxt;
         k_q      <= k_nxt;
         load_c_q <= load_c_nxt;
      end
   end

   // Registered array-edge and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q  <= 1'b0;
         en_left  <= '0;
         en_up    <= '0;
         cin_left <= '0;
         cm_left  <= 1'b0;
         feed_t   <= '0;
         type_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         ready_q  <= (state_nxt == IDLE);
         en_left  <= (state_nxt == STREAM) ? row_win : '0;
         en_up    <= (state_nxt == STREAM) ? col_win : '0;
         cin_left <= cin_nxt;
         cm_left  <= (state_nxt == DRAIN) && (d_nxt == '0);
         feed_t   <= (state_nxt == STREAM) ? t_nxt : '0;
         busy     <= (state_nxt == STREAM) || (state_nxt == DRAIN);
         done     <= (state_nxt == DONE);
         if (accept) begin
            type_out <= cmd.cmd_type;
         end
      end
   end

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Self-checking bench for systolic_tile_sched: timeline reference model,
// per-cycle compare, directed literal checks and randomized traffic.
module tb_systolic_tile_sched;
   import systolic_tile_sched_pkg::*;

   localparam int N    = 4;
   localparam int KMAX = 256;
   localparam int KW   = $clog2(KMAX + 1);
   localparam int TW   = $clog2(KMAX + 3 * N);

   logic          clk = 1'b0;
   logic          rst;
   logic          abort;
   logic [N-1:0]  en_left;
   logic [N-1:0]  en_up;
   logic [N-1:0]  cin_left;
   logic          cm_left;
   logic [TW-1:0] feed_t;
   full_type_t    type_out;
   logic          busy;
   logic          done;

   systolic_tile_sched_if #(.KW(KW)) cmd_bus ();

   systolic_tile_sched #(
      .N    (N),
      .KMAX (KMAX),
      .KW   (KW),
      .TW   (TW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cmd_bus),
      .abort    (abort),
      .en_left  (en_left),
      .en_up    (en_up),
      .cin_left (cin_left),
      .cm_left  (cm_left),
      .feed_t   (feed_t),
      .type_out (type_out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a tile is a timeline indexed by cycles since accept
   int           m_age = 0;
   int           m_len = 0;
   int           m_k = 0;
   int           m_t = 0;
   logic         m_load = 1'b0;
   logic         m_acc = 1'b0;
   logic         exp_ready = 1'b0;
   logic [N-1:0] exp_en = '0;
   logic [N-1:0] exp_cin = '0;
   logic         exp_cm = 1'b0;
   int           exp_feed = 0;
   full_type_t   exp_type = '0;
   logic         exp_busy = 1'b0;
   logic         exp_done = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_age = 0;
      m_len = 0;
      m_k = 0;
      m_load = 1'b0;
      exp_type = '0;
      exp_ready = 1'b0;
      exp_en = '0;
      exp_cin = '0;
      exp_cm = 1'b0;
      exp_feed = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
   endtask

   task automatic model_step();
      m_acc = cmd_bus.cmd_valid && exp_ready;
      if (m_age != 0) begin
         if (m_age >= m_len) m_age = 0;
         else if (abort) m_age = 0;
         else m_age++;
      end else if (m_acc) begin
         m_k = (int'(cmd_bus.cmd_k_len) > KMAX) ? KMAX : int'(cmd_bus.cmd_k_len);
         m_load = cmd_bus.cmd_load_c;
         exp_type = cmd_bus.cmd_type;
         m_age = 1;
         m_len = (m_k == 0) ? 1 : m_k + 3 * N - 1;
      end
      exp_en = '0;
      exp_cin = '0;
      exp_cm = 1'b0;
      exp_feed = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_ready = (m_age == 0);
      if (m_age != 0) begin
         if (m_k == 0) begin
            exp_done = 1'b1;
         end else if (m_age <= m_k + N - 1) begin
            m_t = m_age - 1;
            for (int i = 0; i < N; i++) begin
               exp_en[i] = (m_t >= i) && (m_t < i + m_k);
               exp_cin[i] = m_load && (m_t == i);
            end
            exp_feed = m_t;
            exp_busy = 1'b1;
         end else if (m_age <= m_k + 3 * N - 2) begin
            exp_busy = 1'b1;
            exp_cm = (m_age == m_k + N);
         end else begin
            exp_done = 1'b1;
         end
      end
   endtask

   // Advance the reference model on every clock edge and on reset
   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   // Compare every DUT output against the model mid-cycle
   always @(negedge clk) begin
      check_output("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(exp_ready));
      check_output("en_left", 32'(en_left), 32'(exp_en));
      check_output("en_up", 32'(en_up), 32'(exp_en));
      check_output("cin_left", 32'(cin_left), 32'(exp_cin));
      check_output("cm_left", 32'(cm_left), 32'(exp_cm));
      check_output("feed_t", 32'(feed_t), 32'(exp_feed));
      check_output("type_out", 32'(type_out), 32'(exp_type));
      check_output("busy", 32'(busy), 32'(exp_busy));
      check_output("done", 32'(done), 32'(exp_done));
   end

   // Wait for cmd_ready, present one command, return just after the accept edge
   task automatic apply_stimulus(input int k, input logic lc, input full_type_t ty);
      int waited = 0;
      @(negedge clk);
      while (cmd_bus.cmd_ready !== 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (cmd_bus.cmd_ready !== 1'b1) check_output("send_ready_timeout", 32'(cmd_bus.cmd_ready), 32'd1);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_k_len = KW'(k);
      cmd_bus.cmd_load_c = lc;
      cmd_bus.cmd_type = ty;
      @(posedge clk);
      #1;
      cmd_bus.cmd_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_en_left"}, 32'(en_left), 32'd0);
      check_output({tag, "_en_up"}, 32'(en_up), 32'd0);
      check_output({tag, "_cin"}, 32'(cin_left), 32'd0);
      check_output({tag, "_cm"}, 32'(cm_left), 32'd0);
      check_output({tag, "_feed"}, 32'(feed_t), 32'd0);
      check_output({tag, "_type"}, 32'(type_out), 32'd0);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_done"}, 32'(done), 32'd0);
      check_output({tag, "_ready"}, 32'(cmd_bus.cmd_ready), 32'd0);
   endtask

   int cnt;
   int r;
   int kk;

   initial begin
      rst = 1'b0;
      abort = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_k_len = '0;
      cmd_bus.cmd_load_c = 1'b0;
      cmd_bus.cmd_type = '0;
      #7;
      check_all_zero("reset");
      @(posedge clk);
      #2;
      rst = 1'b1;

      // K=3, load_c=1: hand-computed timeline
      apply_stimulus(3, 1'b1, 3'd2);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check_output("s1_en_c1", 32'(en_left), 32'b0001);
            check_output("s1_cin_c1", 32'(cin_left), 32'b0001);
            check_output("s1_type_c1", 32'(type_out), 32'd2);
         end
         if (c == 2) check_output("s1_en_c2", 32'(en_left), 32'b0011);
         if (c == 3) check_output("s1_en_c3", 32'(en_left), 32'b0111);
         if (c == 4) begin
            check_output("s1_en_c4", 32'(en_left), 32'b1110);
            check_output("s1_enup_c4", 32'(en_up), 32'b1110);
            check_output("s1_cin_c4", 32'(cin_left), 32'b1000);
         end
         if (c == 6) begin
            check_output("s1_en_c6", 32'(en_left), 32'b1000);
            check_output("s1_feed_c6", 32'(feed_t), 32'd5);
         end
         if (c == 7) begin
            check_output("s1_cm_c7", 32'(cm_left), 32'd1);
            check_output("s1_en_c7", 32'(en_left), 32'd0);
         end
         if (c == 8) check_output("s1_cm_c8", 32'(cm_left), 32'd0);
         if (c == 13) check_output("s1_busy_c13", 32'(busy), 32'd1);
         if (c == 14) begin
            check_output("s1_done_c14", 32'(done), 32'd1);
            check_output("s1_ready_c14", 32'(cmd_bus.cmd_ready), 32'd0);
         end
         if (c == 15) begin
            check_output("s1_ready_c15", 32'(cmd_bus.cmd_ready), 32'd1);
            check_output("s1_done_c15", 32'(done), 32'd0);
         end
      end

      // K=0: immediate done, no edge activity
      apply_stimulus(0, 1'b1, 3'd7);
      @(negedge clk);
      check_output("k0_done_c1", 32'(done), 32'd1);
      check_output("k0_en_c1", 32'(en_left), 32'd0);
      check_output("k0_busy_c1", 32'(busy), 32'd0);
      @(negedge clk);
      check_output("k0_ready_c2", 32'(cmd_bus.cmd_ready), 32'd1);
      check_output("k0_done_c2", 32'(done), 32'd0);

      // K=300 clamps to 256
      apply_stimulus(300, 1'b1, 3'd6);
      cnt = 0;
      for (int c = 1; c <= 270; c++) begin
         @(negedge clk);
         if (en_left[0]) cnt++;
         if (c == 267) check_output("clamp_done", 32'(done), 32'd1);
      end
      check_output("clamp_en0_cycles", 32'(cnt), 32'd256);

      // Abort while t=2
      apply_stimulus(5, 1'b1, 3'd3);
      @(posedge clk);
      @(posedge clk);
      #2;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check_output("abort_en_left", 32'(en_left), 32'd0);
      check_output("abort_en_up", 32'(en_up), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_ready", 32'(cmd_bus.cmd_ready), 32'd1);
      check_output("abort_type_kept", 32'(type_out), 32'd3);
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_output("abort_no_done", 32'(cnt), 32'd0);
      apply_stimulus(2, 1'b0, 3'd1);
      cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_output("after_abort_done", 32'(cnt), 32'd1);

      // Async reset mid-DRAIN, then a clean tile without accumulator load
      apply_stimulus(3, 1'b1, 3'd5);
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      @(posedge clk);
      #2;
      rst = 1'b1;
      apply_stimulus(3, 1'b0, 3'd4);
      cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (cin_left != '0) cnt++;
         if (c == 1) check_output("rst2_en_c1", 32'(en_left), 32'b0001);
         if (c == 4) check_output("rst2_en_c4", 32'(en_left), 32'b1110);
         if (c == 14) check_output("rst2_done_c14", 32'(done), 32'd1);
      end
      check_output("rst2_no_cin", 32'(cnt), 32'd0);

      // cmd_valid held high with a changing type every cycle
      cmd_bus.cmd_valid = 1'b1;
      repeat (150) begin
         @(posedge clk);
         #2;
         cmd_bus.cmd_type = full_type_t'($urandom_range(0, 7));
         cmd_bus.cmd_k_len = KW'($urandom_range(0, 5));
         cmd_bus.cmd_load_c = 1'($urandom_range(0, 1));
      end
      cmd_bus.cmd_valid = 1'b0;

      // Randomized traffic with occasional long tiles and aborts
      repeat (4000) begin
         @(posedge clk);
         #2;
         cmd_bus.cmd_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 19);
         if (r < 2) kk = 0;
         else if (r == 19) kk = $urandom_range(240, 320);
         else kk = $urandom_range(1, 12);
         cmd_bus.cmd_k_len = KW'(kk);
         cmd_bus.cmd_load_c = 1'($urandom_range(0, 1));
         cmd_bus.cmd_type = full_type_t'($urandom_range(0, 7));
         abort = ($urandom_range(0, 40) == 0);
      end
      cmd_bus.cmd_valid = 1'b0;
      abort = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_tile_sched.md
Name: systolic_tile_sched

Overview:
- Tile sequencer for the N×N systolic PE array.
- Accepts one matrix-multiply tile command (reduction depth K, compute type, accumulator-load flag) through a valid/ready handshake.
- Drives the array's edge enables: `en` per row on the left edge and per column on the top edge, the skewed `cin` load strobe, and the compute-mode strobe. The PEs propagate these themselves.
- Counts the array's fill and drain latency, then reports completion. It sits between the tile command queue and the left and top edges of the PE array.

Parameters:
- N, 8, array dimension (rows = columns = N)
- KMAX, 256, maximum reduction depth per tile
- KW, $clog2(KMAX+1), width of the `k_len` field
- TW, $clog2(KMAX+3*N), width of the internal phase counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  tile command present
- cmd_ready  out  1  scheduler can accept a command; high only in IDLE
- cmd_k_len  in  KW  reduction depth K
- cmd_load_c  in  1  1 = preload accumulators from the `c` chain at tile start
- cmd_type  in  params::full_type_t  compute type for this tile
- abort  in  1  synchronous abort of the current tile
- en_left  out  N  per-row `en` into column 0
- en_up  out  N  per-column `en` into row 0
- cin_left  out  N  per-row `cin` strobe into column 0
- cm_left  out  1  compute-mode strobe into PE[0][0]
- feed_t  out  TW  current STREAM cycle index; the external A/B buffers apply matching skew
- type_out  out  params::full_type_t  latched compute type
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle tile-complete pulse

Behaviour:
- All outputs are registered. While rst=0, every output is 0, type_out is 0, and the state is IDLE.
- States:
  - IDLE→STREAM on cmd_valid&&cmd_ready with K≥1.
  - IDLE→DONE when the accepted K=0; no enables are issued.
  - STREAM→DRAIN when t = K+N-2.
  - DRAIN→DONE when d = 2N-2.
  - DONE→IDLE unconditionally.
- On accept:
  - Latch K, clamped to KMAX if larger.
  - Latch load_c and type; type_out updates the cycle after accept and holds until the next accept.
  - Clear t and d.
- STREAM lasts K+N-1 cycles, with t counting 0 to K+N-2.
  - en_left[i] = (t ≥ i) && (t < i+K); en_up[j] uses the same window with j.
  - cin_left[i] = load_c && (t == i), a one-cycle pulse aligned with row i's first `en`.
  - feed_t = t; it is 0 outside STREAM.
- DRAIN lasts 2N-1 cycles, with d counting 0 to 2N-2.
  - All en and cin outputs are 0.
  - cm_left = 1 for exactly the first DRAIN cycle (d=0).
- DONE: done=1 for one cycle, busy=0, cmd_ready=0. cmd_ready returns to 1 the following cycle.
- Latency: with the accept edge at cycle 0, the first en is at cycle 1 and done is at cycle 1+(K+N-1)+(2N-1).
- cmd_valid outside IDLE is ignored; no back-to-back overlap of tiles.
- abort (STREAM or DRAIN): the next cycle is IDLE with all en, cin and cm outputs 0. No done pulse. type_out is retained. abort in IDLE or DONE has no effect.
- Asynchronous reset mid-tile clears immediately; there is no resume.
- Counter widths must hold KMAX+3N without wrap.

Decomposition:
- params package adds:
  - sched_state_t enum {IDLE, STREAM, DRAIN, DONE}
  - SCHED_KMAX constant
  - DRAIN_LAT(N) = 2N-1 as a localparam function
- One sub-module, wavefront_gen: given t, K and lane index i, it produces the window compare `(t≥i)&&(t<i+K)` for N lanes. It is instantiated once for rows and once for columns, with the outputs registered in the parent.

Test Plan:
- N=4, K=3, load_c=1, accept at cycle 0:
  - en_left[0] high cycles 1–3; en_left[3] high cycles 4–6.
  - cin_left[k] pulses at cycle 1+k.
  - cm_left at cycle 7; done at cycle 14; cmd_ready high at cycle 15.
- N=4, K=0 → no en, cin or cm activity; done at cycle 1; cmd_ready at cycle 2.
- K=300 with KMAX=256 → behaves exactly as K=256 (en_left[0] high for 256 cycles).
- abort in STREAM at t=2 → all enables 0 from the next cycle, IDLE with cmd_ready=1, done never pulses; a following command runs normally.
- rst driven low mid-DRAIN → all outputs 0 asynchronously. After release, a command with load_c=0 produces no cin pulse and en windows as in the first scenario.
- cmd_valid held high continuously with varying cmd_type → exactly one accept per tile; type_out changes only on the cycle after each accept.
